// File: rtl/rand_perm3_unmap.sv
// Inverse of the 3-slot random permutation mapper: a two-stage valid/ready pipeline
// that recovers the original slot order, plus saturating per-permutation histogram counters.

module rand_perm3_hist_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end
endmodule

module rand_perm3_unmap #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_y,
    input  logic [6:0]       in_random,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_x,
    output logic [2:0]       out_perm,
    input  logic [2:0]       hist_sel,
    output logic [CNT_W-1:0] hist_count,
    input  logic             hist_clear
);
    logic [2:1]             vld_pipe;
    logic [5:0]             s1_y;
    logic [2:0]             s1_k;
    logic [2:0]             k;
    logic [5:0]             x;
    logic                   s2_load;
    logic                   in_xfer;
    logic [7:0][CNT_W-1:0]  cnt;

    // Six near-equal bins over the 7-bit random range
    always_comb begin
        if (in_random <= 7'd20)       k = 3'd0;
        else if (in_random <= 7'd41)  k = 3'd1;
        else if (in_random <= 7'd63)  k = 3'd2;
        else if (in_random <= 7'd84)  k = 3'd3;
        else if (in_random <= 7'd105) k = 3'd4;
        else                          k = 3'd5;
    end

    always_comb begin
        x = s1_y;
        case (s1_k)
            3'd0:    x = {s1_y[5:4], s1_y[3:2], s1_y[1:0]};
            3'd1:    x = {s1_y[3:2], s1_y[5:4], s1_y[1:0]};
            3'd2:    x = {s1_y[5:4], s1_y[1:0], s1_y[3:2]};
            3'd3:    x = {s1_y[1:0], s1_y[5:4], s1_y[3:2]};
            3'd4:    x = {s1_y[3:2], s1_y[1:0], s1_y[5:4]};
            3'd5:    x = {s1_y[1:0], s1_y[3:2], s1_y[5:4]};
            default: x = s1_y;
        endcase
    end

    assign s2_load   = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || s2_load;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_y     <= '0;
            s1_k     <= '0;
            out_x    <= '0;
            out_perm <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_y <= in_y;
                    s1_k <= k;
                end
            end
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_x    <= x;
                    out_perm <= s1_k;
                end
            end
        end
    end

    // Selects 6 and 7 read as permanently zero entries
    for (genvar i = 0; i < 8; i++) begin : g_hist
        if (i < 6) begin : g_cnt
            rand_perm3_hist_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (hist_clear),
                .inc   (in_xfer && (k == 3'(i))),
                .count (cnt[i])
            );
        end else begin : g_zero
            assign cnt[i] = '0;
        end
    end

    assign hist_count = cnt[hist_sel];
endmodule
